// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants (active-high, {g,f,e,d,c,b,a})
// and the output polarity helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic [6:0] seg_polarity(input logic [6:0] pat, input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-coherent shadow latch,
// per-slot dead cycle, leading-zero blanking and registered pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE    = {NUM_DIGITS{SEG_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_IDLE   = seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
  localparam logic                  DP_IDLE    = SEG_ACTIVE_LOW;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    tick;
  logic                    frame_load;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_run;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              cur_pat;
  logic [NUM_DIGITS-1:0]   an_hi;
  logic [6:0]              seg_hi;
  logic                    dp_hi;

  // Scan counter and frame-boundary shadow load
  always_comb begin
    tick         = en && (presc_q == PRESC_LAST);
    frame_load   = tick && (idx_q == IDX_LAST);
    presc_d      = presc_q;
    idx_d        = idx_q;
    shadow_dig_d = shadow_dig_q;
    shadow_dp_d  = shadow_dp_q;
    if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    if (frame_load) begin
      shadow_dig_d = digits_in;
      shadow_dp_d  = dp_in;
    end
  end

  assign frame_start = frame_load;

  // Blanking walks down from the top digit; a set dp ends the zero run
  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      zero_run = zero_run
                 && (shadow_dig_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0)
                 && !shadow_dp_q[NUM_DIGITS-1-k];
      blank[NUM_DIGITS-1-k] = BLANK_LEADING && zero_run;
    end
  end

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code  = shadow_dig_q[4*i +: 4];
        cur_dp    = shadow_dp_q[i];
        cur_blank = blank[i];
        an_sel[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .code (cur_code),
    .seg  (cur_pat)
  );

  always_comb begin
    an_hi  = '0;
    seg_hi = SEG_OFF;
    dp_hi  = 1'b0;
    if (en && (presc_q != '0)) begin
      an_hi  = an_sel;
      seg_hi = cur_blank ? SEG_OFF : cur_pat;
      dp_hi  = cur_dp;
    end
    an_d  = SEG_ACTIVE_LOW ? ~an_hi : an_hi;
    seg_d = seg_polarity(seg_hi, SEG_ACTIVE_LOW);
    dp_d  = dp_hi ^ SEG_ACTIVE_LOW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_dig_q <= '0;
      shadow_dp_q  <= '0;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the BCD decimal counters: takes NUM_DIGITS packed BCD digits and time-multiplexes them onto one shared 7-segment bus with per-digit anode selects.
- Provides a frame-coherent shadow latch, a dead cycle in every digit slot against ghosting, leading-zero blanking and invalid-code display.
- Sits between the counter chain and the board pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- SCAN_DIV, 4: clock cycles per digit slot (>=2); 4 for simulation, ~50000 on board.
- SEG_ACTIVE_LOW, 1: 1 means seg/dp/an are driven active-low (common anode).
- BLANK_LEADING, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  scan enable
- digits_in  in  4*NUM_DIGITS  packed BCD; digit 0 (rightmost) at [3:0]
- dp_in  in  NUM_DIGITS  decimal point per digit; bit i belongs to digit i
- seg  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point of the currently selected digit
- an  out  NUM_DIGITS  one-hot digit select; bit i drives digit i
- frame_start  out  1  one-cycle pulse on the edge where the shadow registers load

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, also mid-scan):
  - prescaler=0, idx=0, shadow digits=0, shadow dp=0.
  - an, seg and dp all inactive; with SEG_ACTIVE_LOW=1 that is an=all 1s, seg=7'h7F, dp=1.
  - frame_start=0.
- Prescaler counts 0..SCAN_DIV-1 while en=1, then wraps. tick = (prescaler==SCAN_DIV-1).
- On tick, idx advances to (idx+1) mod NUM_DIGITS.
- On a tick with idx==NUM_DIGITS-1:
  - digits_in and dp_in load into the shadow registers on the same edge.
  - frame_start=1 for that one cycle.
  - The displayed data therefore changes only between frames.
- Outputs are registered and computed from (idx, prescaler, shadow), giving 1 cycle of latency:
  - If prescaler==0 (dead cycle), an, seg and dp are all inactive.
  - Otherwise an selects idx only, and seg/dp show shadow digit idx.
  - Each digit is lit for SCAN_DIV-1 cycles per slot.
- Decode, active-high patterns (inverted when SEG_ACTIVE_LOW=1):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - Codes 10..15 show a dash, 40.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i>=1 is blanked when it and every higher digit are 0 and none of their dp bits is set.
  - Blanked means an is still driven and dp follows its shadow bit, but seg is all off.
  - Digit 0 is never blanked.
- en=0:
  - prescaler and idx hold, no shadow load, frame_start=0.
  - Outputs go inactive one cycle later.
  - On en=1 the scan resumes from the held state.
- Simultaneous tick and frame load: the new shadow values are used from the first cycle of the digit-0 slot.

Decomposition:
- Shared package seg7_pkg: the seg code constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and a function for active-low polarity application.
- One sub-module, bcd_to_seg7: combinational, 4-bit code to 7-bit active-high pattern, dash for codes >9.
- Blanking mask, scan counter and output registers stay in the top level.

Test Plan:
All cases use NUM_DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=1.
1. Reset:
   - Stimulus: rst=0 with en=1, hold 20ns.
   - Required: an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
2. Scan:
   - Stimulus: digits_in=16'h1234, dp_in=0; release reset; wait for one frame_start.
   - Required per slot, each lit 3 cycles after 1 dark cycle:
     - an=1110 with seg=7'h19
     - an=1101 with seg=7'h30
     - an=1011 with seg=7'h24
     - an=0111 with seg=7'h79
   - frame_start repeats every 16 cycles.
3. Blanking:
   - digits_in=16'h0040 → digits 3 and 2 show seg=7'h7F with their an bits still active; digit 1 shows 7'h19; digit 0 shows 7'h40.
   - digits_in=16'h0000 → only digit 0 lights, showing 7'h40.
   - dp_in=4'b0100 with digits_in=16'h0040 → digit 2 shows 7'h40 with dp=0.
4. Frame coherence:
   - Stimulus: change digits_in from 16'h1234 to 16'h5678 during the digit-1 slot.
   - Required: the remaining slots still show 3 and then 1; 8/7/6/5 appear only after the next frame_start.
5. Invalid code:
   - Stimulus: digits_in=16'h000A.
   - Required: digit 0 shows seg=7'h3F (dash).
6. Enable and async reset:
   - Stimulus: en=0 mid-slot.
   - Required: outputs inactive next cycle and idx held; on en=1 the scan resumes in the same slot.
   - Stimulus: rst=0 at 3ns past a clock edge.
   - Required: outputs reach reset values before the next edge.
